// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator definitions: layer-1 weight ROM geometry and the
// loader FSM state encoding, reused by the conv2/fc weight loaders.
package lenet_pkg;

    // conv1 weight ROM geometry
    localparam int W1_KSIZE  = 25;   // taps per 5x5 kernel, one ROM word each
    localparam int W1_AW     = 5;    // ROM address width
    localparam int W1_DW     = 48;   // 6 filters x 8-bit taps, filter 1 in [7:0]
    localparam int W1_RD_LAT = 1;    // registered ROM output

    // Loader sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ld_state_t;

    // A new ROM read may be launched when the words already in flight plus
    // the words that will still sit in the 2-entry output buffer after this
    // cycle's pop leave room for one more.
    function automatic logic ld_credit_ok(input int inflight, input int held, input int pops);
        return (inflight + held - pops) < 2;
    endfunction

endpackage

// File: rtl/w1_ld_skid.sv
// Two-entry valid/ready output buffer for the weight loader. Entry 0 is the
// head presented downstream; entry 1 absorbs a word that returns from the
// ROM while the head is stalled. The upstream credit logic guarantees a push
// never arrives when both entries are occupied and no pop happens.
module w1_ld_skid #(
    parameter int W = 54
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_word,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_word,
    output logic [1:0]   count
);

    logic [W-1:0] ent0_reg;
    logic [W-1:0] ent1_reg;
    logic [1:0]   cnt_reg;
    logic         pop;

    assign pop      = out_vld && out_rdy;
    assign out_vld  = (cnt_reg != 2'd0);
    assign out_word = ent0_reg;
    assign count    = cnt_reg;

    // Buffer occupancy and entry shifting; head moves up from entry 1 on a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_reg <= '0;
            ent1_reg <= '0;
            cnt_reg  <= 2'd0;
        end else if (flush) begin
            cnt_reg <= 2'd0;
        end else begin
            unique case (cnt_reg)
                2'd0: begin
                    if (in_vld) begin
                        ent0_reg <= in_word;
                        cnt_reg  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_vld && pop) begin
                        ent0_reg <= in_word;
                    end else if (in_vld) begin
                        ent1_reg <= in_word;
                        cnt_reg  <= 2'd2;
                    end else if (pop) begin
                        cnt_reg <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        ent0_reg <= ent1_reg;
                        if (in_vld) begin
                            ent1_reg <= in_word;
                        end else begin
                            cnt_reg <= 2'd1;
                        end
                    end
                end
                default: begin
                    cnt_reg <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/w1_load_ctrl.sv
// conv1 weight loader: on start, sweeps the weight ROM from address 0 to
// KSIZE-1 and streams each word, tagged with its tap index, to the PE array
// over valid/ready. ROM reads are throttled by a credit so the 2-entry output
// buffer can never overflow, while still sustaining one word per cycle when
// the PE array is always ready.
// Optional build macro W1_LD_ABORT_EN adds an abort input that cancels a
// sweep in progress (no done pulse).
module w1_load_ctrl
    import lenet_pkg::*;
#(
    parameter int KSIZE  = W1_KSIZE,
    parameter int AW     = W1_AW,
    parameter int DW     = W1_DW,
    parameter int RD_LAT = W1_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef W1_LD_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] w1_raddr,
    input  logic [DW-1:0] w1_rdata,
    output logic          wt_vld,
    input  logic          wt_rdy,
    output logic [AW-1:0] wt_idx,
    output logic [DW-1:0] wt_data,
    output logic          wt_last
);

    localparam int          IW       = $clog2(RD_LAT + 1);
    localparam int          WW       = AW + 1 + DW;
    localparam logic [AW-1:0] LAST_IDX = AW'(KSIZE - 1);

    ld_state_t     state_reg;
    ld_state_t     state_next;
    logic [AW-1:0] issue_cnt_reg;
    logic [AW-1:0] issue_cnt_next;
    logic          issue_fire;
    logic          abort_hit;
    logic          credit_ok;
    logic          pop;

    // Read-return tracking: one valid bit and tap index per cycle of ROM latency
    logic [RD_LAT-1:0] tag_vld_reg;
    logic [AW-1:0]     tag_idx_reg [RD_LAT];
    logic [IW-1:0]     inflight;

    logic          cap_vld;
    logic [AW-1:0] cap_idx;
    logic          cap_last;
    logic [WW-1:0] cap_word;
    logic [WW-1:0] head_word;
    logic [1:0]    held_cnt;

`ifdef W1_LD_ABORT_EN
    assign abort_hit = abort && ((state_reg == ISSUE) || (state_reg == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    assign busy     = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign done     = (state_reg == DONE);
    assign w1_raddr = issue_cnt_reg;
    assign pop      = wt_vld && wt_rdy;

    // Count reads launched whose data has not yet been captured
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IW'(tag_vld_reg[i]);
        end
    end

    assign credit_ok = ld_credit_ok(int'(inflight), int'(held_cnt), int'(pop));

    // FSM state and issue counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            issue_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            issue_cnt_reg <= issue_cnt_next;
        end
    end

    // Next-state, address issue and sweep termination
    always_comb begin
        state_next     = state_reg;
        issue_cnt_next = issue_cnt_reg;
        issue_fire     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (abort_hit) begin
                    state_next     = IDLE;
                    issue_cnt_next = '0;
                end else if (credit_ok) begin
                    issue_fire = 1'b1;
                    if (issue_cnt_reg == LAST_IDX) begin
                        // Address stays on the last tap until the sweep ends
                        state_next = DRAIN;
                    end else begin
                        issue_cnt_next = issue_cnt_reg + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (abort_hit) begin
                    state_next     = IDLE;
                    issue_cnt_next = '0;
                end else if (pop && wt_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next     = IDLE;
                issue_cnt_next = '0;
            end
            default: begin
                state_next     = IDLE;
                issue_cnt_next = '0;
            end
        endcase
    end

    // Shift the issue tag alongside the ROM pipeline so data arrives tagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_reg <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_idx_reg[i] <= '0;
            end
        end else if (abort_hit) begin
            tag_vld_reg <= '0;
        end else begin
            tag_vld_reg[0] <= issue_fire;
            tag_idx_reg[0] <= issue_cnt_reg;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_reg[i] <= tag_vld_reg[i-1];
                tag_idx_reg[i] <= tag_idx_reg[i-1];
            end
        end
    end

    assign cap_vld  = tag_vld_reg[RD_LAT-1];
    assign cap_idx  = tag_idx_reg[RD_LAT-1];
    assign cap_last = (cap_idx == LAST_IDX);
    assign cap_word = {cap_idx, cap_last, w1_rdata};

    w1_ld_skid #(
        .W (WW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (abort_hit),
        .in_vld   (cap_vld),
        .in_word  (cap_word),
        .out_vld  (wt_vld),
        .out_rdy  (wt_rdy),
        .out_word (head_word),
        .count    (held_cnt)
    );

    assign wt_idx  = head_word[WW-1 -: AW];
    assign wt_last = head_word[DW];
    assign wt_data = head_word[DW-1:0];

endmodule
